// File: rtl/tdm_demux_1_4_pkg.sv
// Shared definitions for the 1:4 TDM demultiplexer: FSM encoding and frame geometry.
package tdm_demux_1_4_pkg;

    localparam int unsigned SLOTS  = 4;
    localparam int unsigned SLOT_W = $clog2(SLOTS);

    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } state_e;

endpackage

// File: rtl/slot_counter_2b.sv
// Slot counter: wraps 3 -> 0. With load0 and en together it restarts at slot 0 and
// steps past it in the same cycle, which is what a resync capture needs.
module slot_counter_2b
    import tdm_demux_1_4_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load0,
    output logic [SLOT_W-1:0] cnt
);

    logic [SLOT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load0) begin
            cnt_q <= en ? SLOT_W'(1) : '0;
        end else if (en) begin
            cnt_q <= cnt_q + SLOT_W'(1);
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/tdm_demux_1_4.sv
// 1:4 TDM demultiplexer: hunts for sync, collects four serial bits into slots 0..3 and
// presents each completed frame on y with a one-cycle y_valid pulse.
module tdm_demux_1_4
    import tdm_demux_1_4_pkg::*;
#(
    parameter bit SYNC_REQUIRED = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             sync,
    output logic             s0,
    output logic             s1,
    output logic [SLOTS-1:0] y,
    output logic             y_valid,
    output logic             frame_err
);

    state_e            state_q, state_d;
    logic [SLOTS-1:0]  shreg_q, shreg_d;
    logic [SLOTS-1:0]  y_q, y_d;
    logic              y_valid_q, y_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              cnt_en, cnt_load0;
    logic [SLOT_W-1:0] slot;

    slot_counter_2b u_slot_counter (
        .clk   (clk),
        .rst   (rst),
        .en    (cnt_en),
        .load0 (cnt_load0),
        .cnt   (slot)
    );

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        y_d         = y_q;
        y_valid_d   = 1'b0;
        frame_err_d = 1'b0;
        cnt_en      = 1'b0;
        cnt_load0   = 1'b0;

        if (din_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (sync) begin
                        shreg_d = {{(SLOTS-1){1'b0}}, din};
                        cnt_en  = 1'b1;
                        state_d = COLLECT;
                    end
                end
                COLLECT: begin
                    if (sync && slot != '0) begin
                        // Resync: drop the partial frame, this bit becomes slot 0.
                        frame_err_d = 1'b1;
                        shreg_d     = {{(SLOTS-1){1'b0}}, din};
                        cnt_load0   = 1'b1;
                        cnt_en      = 1'b1;
                    end else if (!sync && slot == '0 && SYNC_REQUIRED) begin
                        frame_err_d = 1'b1;
                        shreg_d     = '0;
                        cnt_load0   = 1'b1;
                        state_d     = HUNT;
                    end else begin
                        cnt_en = 1'b1;
                        if (slot == SLOT_W'(SLOTS - 1)) begin
                            y_d       = {din, shreg_q[SLOTS-2:0]};
                            y_valid_d = 1'b1;
                            shreg_d   = '0;
                        end else begin
                            shreg_d[slot] = din;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HUNT;
            shreg_q     <= '0;
            y_q         <= '0;
            y_valid_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            y_q         <= y_d;
            y_valid_q   <= y_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign s0        = slot[0];
    assign s1        = slot[1];
    assign y         = y_q;
    assign y_valid   = y_valid_q;
    assign frame_err = frame_err_q;

endmodule
